frequency_meter: RTL
====================

FREQUENCY_METER -- requirements
Module: frequency_meter

Interface
REQ-001 Parameter WIDTH, default 28: width of the period and high-time counters and outputs.
REQ-002 Parameter TIMEOUT, default 28'd100000000: cycles without a rising edge before a measurement is abandoned; SHALL satisfy 2 <= TIMEOUT <= 2^WIDTH-1.
REQ-003 clock_in  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 signal_in  input  1  measured signal; may be asynchronous to clock_in.
REQ-006 period_out  output  WIDTH  last measured period in clock_in cycles (rise to rise).
REQ-007 high_out  output  WIDTH  last measured high time in clock_in cycles.
REQ-008 period_valid  output  1  one-cycle pulse; period_out/high_out updated that same cycle.
REQ-009 timeout  output  1  level; high while no valid periodic signal is present.

Function
REQ-010 signal_in SHALL pass through a 2-flop synchronizer (s1, s2) and one edge-detect flop s3; rise = s2 & ~s3.
REQ-011 Measurement SHALL be exact for a signal synchronous to clock_in; the synchronizer delays both edges equally, so latency does not affect the count.
REQ-012 FSM states: WAIT_LOW, ARM, MEASURE.
REQ-013 WAIT_LOW: go to ARM when s2 == 0; rise ignored in this state.
REQ-014 ARM: on rise, go to MEASURE with cnt <= 1, hcnt <= 1; no output update.
REQ-015 MEASURE, no rise: cnt <= cnt+1; hcnt <= hcnt+1 when s2 == 1, else unchanged.
REQ-016 MEASURE, rise: period_out <= cnt, high_out <= hcnt, period_valid <= 1 for one cycle, timeout <= 0, cnt <= 1, hcnt <= 1; remain in MEASURE.
REQ-017 MEASURE, no rise and cnt == TIMEOUT-1: timeout <= 1, go to WAIT_LOW; period_out/high_out hold their last values.
REQ-018 Rise and timeout condition in the same cycle: rise wins (REQ-016).
REQ-019 cnt and hcnt SHALL never wrap; REQ-017 bounds cnt below TIMEOUT, and hcnt <= cnt always.
REQ-020 Minimum measurable period is 2 (rise every 2 cycles); result period_out=2, high_out=1.
REQ-021 signal_in constantly high or constantly low SHALL give timeout=1 with no period_valid pulses.
REQ-022 period_valid SHALL be 0 in every cycle not covered by REQ-016.

Reset
REQ-023 While reset=1: s1, s2, s3, cnt, hcnt, period_out, high_out, period_valid <= 0; timeout <= 1; state <= WAIT_LOW.
REQ-024 Reset asserted mid-measurement SHALL discard the partial count; no period_valid pulse occurs during or as a result of reset.
REQ-025 signal_in high throughout reset release SHALL NOT produce a measurement; its false rise is absorbed by WAIT_LOW.
REQ-026 The first period_valid after reset SHALL occur on the second qualifying rise (ARM then MEASURE).

Verification
REQ-027 Drive signal_in from a divider with DIVISOR=10 (5 cycles high, 5 low) -> first period_valid on second rise; period_out=10, high_out=5, timeout=0; repeats every 10 cycles.
REQ-028 signal_in toggling every cycle -> period_out=2, high_out=1, period_valid every 2nd cycle.
REQ-029 TIMEOUT=20; signal_in held low after a 10-cycle period -> timeout rises 20 cycles after last rise; period_out stays 10; next two rises -> timeout=0 on the second.
REQ-030 signal_in=1 during reset, period 8 / high 3 afterwards -> no pulse until second real rise after the first low; then period_out=8, high_out=3.
REQ-031 Assert reset for 1 cycle mid-period (cnt=6, period 12) -> outputs 0, timeout=1; next valid result equals 12 on the second rise after reset.
REQ-032 Asynchronous signal_in (period 1000.5 cycles nominal) -> period_out alternates within {1000, 1001}, never a glitch value; high_out <= period_out always.

Source files
------------

// File: rtl/frequency_meter.sv
// Measures period and high time of signal_in in clock_in cycles, rise to rise.
// A watchdog flags a missing or stalled signal and restarts the measurement.
module frequency_meter #(
    parameter int unsigned      WIDTH   = 28,
    parameter logic [WIDTH-1:0] TIMEOUT = 28'd100000000
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             signal_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             period_valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARM      = 2'd1,
        MEASURE  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);
    localparam logic [WIDTH-1:0] TIMEOUT_LAST = TIMEOUT - ONE;

    logic             s1_r;
    logic             s2_r;
    logic             s3_r;
    logic [1:0]       prime_r;
    state_t           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] hcnt_r;

    state_t           state_s;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] hcnt_s;
    logic [WIDTH-1:0] period_s;
    logic [WIDTH-1:0] high_s;
    logic             valid_s;
    logic             timeout_s;
    logic             rise_s;
    logic             prime_done_s;

    assign rise_s       = s2_r & ~s3_r;
    // s2 only carries real input data two cycles after reset; before that a
    // reset-cleared 0 must not be mistaken for a genuine low level.
    assign prime_done_s = (prime_r == 2'd2);

    // Synchronizer, edge-detect flop and post-reset priming counter.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            s1_r    <= 1'b0;
            s2_r    <= 1'b0;
            s3_r    <= 1'b0;
            prime_r <= 2'd0;
        end else begin
            s1_r <= signal_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
            if (prime_done_s) begin
                prime_r <= prime_r;
            end else begin
                prime_r <= prime_r + 2'd1;
            end
        end
    end

    // Next-state, counter and output-register logic of the measurement FSM.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        hcnt_s    = hcnt_r;
        period_s  = period_out;
        high_s    = high_out;
        valid_s   = 1'b0;
        timeout_s = timeout;
        case (state_r)
            WAIT_LOW: begin
                if (!s2_r && prime_done_s) begin
                    state_s = ARM;
                end else begin
                    state_s = WAIT_LOW;
                end
            end
            ARM: begin
                if (rise_s) begin
                    state_s = MEASURE;
                    cnt_s   = ONE;
                    hcnt_s  = ONE;
                end else begin
                    state_s = ARM;
                end
            end
            MEASURE: begin
                if (rise_s) begin
                    period_s  = cnt_r;
                    high_s    = hcnt_r;
                    valid_s   = 1'b1;
                    timeout_s = 1'b0;
                    cnt_s     = ONE;
                    hcnt_s    = ONE;
                    state_s   = MEASURE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = WAIT_LOW;
                end else begin
                    cnt_s = cnt_r + ONE;
                    if (s2_r) begin
                        hcnt_s = hcnt_r + ONE;
                    end else begin
                        hcnt_s = hcnt_r;
                    end
                end
            end
            default: begin
                state_s   = WAIT_LOW;
                cnt_s     = '0;
                hcnt_s    = '0;
                timeout_s = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_r      <= WAIT_LOW;
            cnt_r        <= '0;
            hcnt_r       <= '0;
            period_out   <= '0;
            high_out     <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            hcnt_r       <= hcnt_s;
            period_out   <= period_s;
            high_out     <= high_s;
            period_valid <= valid_s;
            timeout      <= timeout_s;
        end
    end

endmodule
